// File: rtl/dadda_mac_sequencer_if.sv
// Operand stream, Dadda tree and result channels of the MAC sequencer bundled together.
// slave = sequencer side, master = producer / tree / consumer side.
interface dadda_mac_sequencer_if;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_a;
  logic [7:0]            in_b;
  logic                  in_last;
  logic [7:0][7:0]       pp_o;
  logic [15:0]           m_o;
  logic [1:0][16:0]      mac_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           out_result;
  logic                  out_overflow;
  logic [7:0]            out_count;

  modport slave (
    input  in_valid, in_a, in_b, in_last, mac_i, out_ready,
    output in_ready, pp_o, m_o, out_valid, out_result, out_overflow, out_count
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mac_i, out_ready,
    input  in_ready, pp_o, m_o, out_valid, out_result, out_overflow, out_count
  );
endinterface

// File: rtl/dadda_mac_sequencer.sv
// Feeds 8x8 partial products + accumulator to the Dadda tree and folds its carry-save result into a saturating acc.
// One pair/cycle; result valid 2 cycles after the last accept; in_ready drops from last accept until the result is taken.
module dadda_mac_sequencer (
  input  logic                   clk,
  input  logic                   rst,
  dadda_mac_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FLUSH  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t           state;
  logic [7:0][7:0]  pp_q;
  logic [7:0][7:0]  pp_d;
  logic             s1_valid;
  logic [15:0]      acc;
  logic             ovf;
  logic [7:0]       cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [15:0]      res_q;
  logic             res_ovf_q;
  logic [7:0]       res_cnt_q;

  logic             accept;
  logic [17:0]      sum18;
  logic             sat;
  logic [15:0]      acc_next;
  logic             ovf_next;
  logic [7:0]       cnt_next;

  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    pp_d = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        pp_d[i][j] = bus.in_a[i] & bus.in_b[j];
      end
    end
  end

  // Carry-propagate add of the tree's two rows; anything above 16 bits saturates.
  assign sum18    = {1'b0, bus.mac_i[0]} + {1'b0, bus.mac_i[1]};
  assign sat      = |sum18[17:16];
  assign acc_next = sat ? 16'hFFFF : sum18[15:0];
  assign ovf_next = ovf | sat;
  assign cnt_next = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      pp_q        <= '0;
      s1_valid    <= 1'b0;
      acc         <= '0;
      ovf         <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_ovf_q   <= 1'b0;
      res_cnt_q   <= '0;
    end else begin
      pp_q     <= accept ? pp_d : '0;
      s1_valid <= accept;

      if (s1_valid) begin
        acc <= acc_next;
        ovf <= ovf_next;
        cnt <= cnt_next;
      end

      case (state)
        ACCUM: begin
          if (accept && bus.in_last) begin
            state      <= FLUSH;
            in_ready_q <= 1'b0;
          end
        end
        FLUSH: begin
          // The last item is always in stage 1 here; capture its fold and clear for the next stream.
          res_q       <= acc_next;
          res_ovf_q   <= ovf_next;
          res_cnt_q   <= cnt_next;
          acc         <= '0;
          ovf         <= 1'b0;
          cnt         <= '0;
          out_valid_q <= 1'b1;
          state       <= OUTPUT;
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ACCUM;
          end
        end
        default: begin
          state       <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.pp_o         = pp_q;
  assign bus.m_o          = acc;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = res_q;
  assign bus.out_overflow = res_ovf_q;
  assign bus.out_count    = res_cnt_q;

endmodule

// File: tb/tb_dadda_mac_sequencer.sv
// Directed bench for dadda_mac_sequencer with a behavioural Dadda tree and a stream-level reference model.
module tb_dadda_mac_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dadda_mac_sequencer_if bus ();

  dadda_mac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Tree stand-in: weighted sum of partial products, returned in carry-save form together with the addend.
  logic [15:0] tree_prod;
  always_comb begin
    tree_prod = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (bus.pp_o[i][j]) tree_prod = tree_prod + (16'd1 << (i + j));
      end
    end
    bus.mac_i[0] = {1'b0, tree_prod ^ bus.m_o};
    bus.mac_i[1] = {tree_prod & bus.m_o, 1'b0};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-stream arithmetic on accepted pairs.
  typedef struct {
    int res;
    bit ovf;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   acc_m = 0;
  bit   ovf_m = 1'b0;
  int   cnt_m = 0;
  int   m_exp = 0;
  bit   hold_prev = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_m = 0;
      ovf_m = 1'b0;
      cnt_m = 0;
      m_exp = 0;
      exp_q.delete();
    end else begin
      m_exp = acc_m;
      if (bus.in_valid && bus.in_ready) begin
        int prod;
        prod = int'(bus.in_a) * int'(bus.in_b);
        if (acc_m + prod > 65535) begin
          acc_m = 65535;
          ovf_m = 1'b1;
        end else begin
          acc_m = acc_m + prod;
        end
        cnt_m = (cnt_m == 255) ? 255 : cnt_m + 1;
        if (bus.in_last) begin
          exp_q.push_back('{acc_m, ovf_m, cnt_m});
          acc_m = 0;
          ovf_m = 1'b0;
          cnt_m = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      chk("m_o", 64'(bus.m_o), 64'(m_exp));
      if (hold_prev) chk("out_valid_held", 64'(bus.out_valid), 64'd1);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out_valid: got out_valid=1 expected no pending result at %0t", $time);
        end else begin
          chk("out_result",   64'(bus.out_result),   64'(exp_q[0].res));
          chk("out_overflow", 64'(bus.out_overflow), 64'(exp_q[0].ovf));
          chk("out_count",    64'(bus.out_count),    64'(exp_q[0].cnt));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
    end
  end

  // Call at posedge+#1; returns at posedge+#1 right after the accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles expected 1");
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: got out_valid=0 for 100 cycles expected 1");
    end
  endtask

  task automatic wait_result(input string name, input int res, input bit ovf, input int cnt);
    bit ok;
    wait_valid(ok);
    if (ok) begin
      chk({name, "_result"},   64'(bus.out_result),   64'(res));
      chk({name, "_overflow"}, 64'(bus.out_overflow), 64'(ovf));
      chk({name, "_count"},    64'(bus.out_count),    64'(cnt));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_pp_o",      64'(bus.pp_o),      64'd0);
    chk("rst_m_o",       64'(bus.m_o),       64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'(bus.out_result), 64'd0);
    chk("rst_count",     64'(bus.out_count),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single item, timing and partial-product layout
    send(8'd200, 8'd250, 1'b1);
    @(negedge clk);
    chk("single_pp_o",      64'(bus.pp_o),      64'hFAFA0000FA000000);
    chk("single_flush_vld", 64'(bus.out_valid), 64'd0);
    chk("single_flush_rdy", 64'(bus.in_ready),  64'd0);
    @(negedge clk);
    chk("single_vld_rise",  64'(bus.out_valid), 64'd1);
    chk("single_result",    64'(bus.out_result), 64'd50000);
    chk("single_overflow",  64'(bus.out_overflow), 64'd0);
    chk("single_count",     64'(bus.out_count), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single_rdy_after", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back stream
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b1);
    wait_result("nogap", 98, 1'b0, 3);

    // Same stream with bubbles
    send(8'd3, 8'd4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("bubble_m_o_12", 64'(bus.m_o), 64'd12);
    @(posedge clk);
    #1;
    send(8'd5, 8'd6, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("bubble_m_o_42", 64'(bus.m_o), 64'd42);
    @(posedge clk);
    #1;
    send(8'd7, 8'd8, 1'b1);
    wait_result("bubble", 98, 1'b0, 3);

    // Saturation, then clean follow-up stream
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    wait_result("sat", 65535, 1'b1, 2);
    send(8'd1, 8'd1, 1'b1);
    wait_result("after_sat", 1, 1'b0, 1);

    // Backpressure
    bus.out_ready = 1'b0;
    send(8'd9, 8'd9, 1'b1);
    wait_valid(ok);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready",  64'(bus.in_ready),   64'd0);
      chk("bp_out_valid", 64'(bus.out_valid),  64'd1);
      chk("bp_result",    64'(bus.out_result), 64'd81);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_release_rdy", 64'(bus.in_ready),  64'd1);
    chk("bp_release_vld", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    send(8'd2, 8'd2, 1'b1);
    wait_result("bp_next", 4, 1'b0, 1);

    // Count saturation
    for (int k = 0; k < 300; k++) send(8'd1, 8'd1, (k == 299));
    wait_result("cnt_sat", 300, 1'b0, 255);

    // Asynchronous reset mid-stream
    send(8'd10, 8'd10, 1'b0);
    send(8'd10, 8'd10, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid),  64'd0);
    chk("mid_rst_in_ready",  64'(bus.in_ready),   64'd1);
    chk("mid_rst_m_o",       64'(bus.m_o),        64'd0);
    chk("mid_rst_pp_o",      64'(bus.pp_o),       64'd0);
    chk("mid_rst_result",    64'(bus.out_result), 64'd0);
    chk("mid_rst_count",     64'(bus.out_count),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'd2, 8'd3, 1'b1);
    wait_result("post_rst", 6, 1'b0, 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dadda_mac_sequencer.md
# dadda_mac_sequencer

Sequential front/back end for the Dadda 8x8 multiply-accumulate tree. Accepts a stream of unsigned 8-bit operand pairs and forms the 64 partial products plus the 16-bit addend for the tree. It then takes back the tree's two 17-bit carry-save rows, resolves them with a carry-propagate add, and keeps a saturating 16-bit running accumulator. When a stream's last item has been folded in, the block presents the accumulated dot product on a valid/ready output.

## Interface
Parameters:
- none (8x8 operands, 16-bit accumulator, 8-bit item count are fixed by the tree)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair this cycle
- in_a  in  8  unsigned multiplicand
- in_b  in  8  unsigned multiplier
- in_last  in  1  final pair of the current accumulation
- pp_o  out  [7:0][7:0]  partial products to tree; pp_o[i][j] = a[i] & b[j], weight 2^(i+j)
- m_o  out  16  addend to tree; always equals accumulator register
- mac_i  in  [1:0][16:0]  carry-save rows from tree; value = mac_i[0] + mac_i[1]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  16  saturated accumulated sum
- out_overflow  out  1  saturation occurred during this accumulation
- out_count  out  8  items in this accumulation, saturating at 255

## Operation
- Stage-1 register: on accept (in_valid & in_ready), load a/b into pp register and set s1_valid. Otherwise clear the pp register to 0 and s1_valid to 0.
- pp_o is driven from the pp register. The tree path is purely combinational from pp_o/m_o to mac_i.
- Fold: when s1_valid=1, compute sum18 = {1'b0,mac_i[0]} + {1'b0,mac_i[1]}.
  - acc_next = (sum18 > 16'hFFFF) ? 16'hFFFF : sum18[15:0].
  - ovf_next = ovf | (sum18 > 16'hFFFF).
  - cnt_next = (cnt==255) ? 255 : cnt+1.
- When s1_valid=0, acc, ovf and cnt hold. Idle bubbles never alter the accumulator.
- FSM states:
  - ACCUM: in_ready=1, out_valid=0. Fold each cycle s1_valid=1. Accepting an item with in_last=1 moves to FLUSH.
  - FLUSH: one cycle, in_ready=0.
    - Folds the last item.
    - At the edge: out_result<=acc_next, out_overflow<=ovf_next, out_count<=cnt_next.
    - Same edge: acc<=0, ovf<=0, cnt<=0, out_valid<=1. Go to OUTPUT.
  - OUTPUT: in_ready=0, out_valid=1, result registers held stable. When out_ready=1: out_valid<=0, go to ACCUM.
- Reset values: state=ACCUM; acc, ovf, cnt, pp register, s1_valid = 0; out_valid, out_result, out_overflow, out_count = 0.
  - Therefore in_ready=1, pp_o=0, m_o=0 during and after reset.
- Reset mid-stream or in OUTPUT discards all partial accumulation and any pending result; no out_valid is produced for that stream.
- A first item with in_last=1 is a length-1 stream. out_count=1.
- out_valid/out_result must not change while out_valid=1 and out_ready=0.

## Timing
- Throughput: one operand pair per cycle in ACCUM. Back-to-back items are correct because m_o reflects the fold performed on the same edge that loads the next pair.
- Latency: a pair accepted at edge E is folded into acc at edge E+1.
- For an in_last pair accepted at edge E, out_valid rises after edge E+1, i.e. visible in the second cycle after the accept cycle.
- Stream turnaround: at least 2 dead cycles for in_ready (FLUSH plus one OUTPUT cycle). More if out_ready is held low.
- Accepting a result (OUTPUT with out_ready=1) leaves in_ready=1 on the very next cycle.
- Critical path: pp register -> tree -> 18-bit CPA -> saturate -> acc/result registers. No additional pipeline stage.

## Test plan
- Single item: a=200, b=250, last=1 -> out_result=50000, out_overflow=0, out_count=1; out_valid rises two cycles after accept.
- Stream with no gaps: (3,4),(5,6),(7,8,last) -> out_result=98, out_count=3. Repeat with in_valid low 2 cycles between items -> identical result, acc unchanged during bubbles.
- Saturation: (255,255),(255,255,last) -> out_result=65535 (16'hFFFF), out_overflow=1, out_count=2. The following stream (1,1,last) -> result 1, overflow 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> in_ready=0 and result stable throughout. Release it -> in_ready=1 next cycle; new stream starts from acc=0.
- Count saturation: 300 items of (1,1), last on the 300th -> out_result=300, out_count=255.
- Reset mid-stream: accept (10,10),(10,10), assert rst -> all outputs 0, in_ready=1, m_o=0 immediately. Then (2,3,last) -> result 6, count 1.
